// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - IF-stage fetch-address generator with prioritised, stall-buffered redirects.
module pc_gen #(
  parameter int unsigned   AW        = 32,
  parameter logic [AW-1:0] RESET_VEC = 32'ha0000000,
  parameter int unsigned   STEP      = 4,
  parameter int unsigned   NUM_REDIR = 3,
  parameter int unsigned   ALIGN     = 2,
  parameter int unsigned   STALL_W   = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_W-1:0]      stall,
  input  logic [NUM_REDIR-1:0]    redir_vld,
  input  logic [NUM_REDIR*AW-1:0] redir_addr,
  output logic [AW-1:0]           pc,
  output logic                    ce,
  output logic                    redir_pend,
  output logic                    misalign
);

  localparam int unsigned   IW         = (NUM_REDIR > 1) ? $clog2(NUM_REDIR) : 1;
  localparam logic [AW-1:0] ALIGN_MASK = {AW{1'b1}} << ALIGN;
  localparam logic [AW-1:0] STEP_V     = AW'(STEP);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          r_state, w_state_nxt;
  logic [AW-1:0]   r_pc, w_pc_nxt;
  logic            r_mis, w_mis_nxt;
  logic            r_pend_vld, w_pend_vld_nxt;
  logic [IW-1:0]   r_pend_idx, w_pend_idx_nxt;
  logic [AW-1:0]   r_pend_addr, w_pend_addr_nxt;

  logic            w_live_vld;
  logic [IW-1:0]   w_live_idx;
  logic [AW-1:0]   w_live_addr;
  logic            w_live_take;
  logic            w_redirect;
  logic [AW-1:0]   w_tgt;

  // Descending scan so the lowest requesting index is the one left standing.
  always_comb begin
    w_live_vld  = 1'b0;
    w_live_idx  = '0;
    w_live_addr = '0;
    for (int i = NUM_REDIR - 1; i >= 0; i--) begin
      if (redir_vld[i]) begin
        w_live_vld  = 1'b1;
        w_live_idx  = IW'(i);
        w_live_addr = redir_addr[i*AW +: AW];
      end
    end
  end

  // Live beats pending on an index tie because it carries the newer address.
  assign w_live_take = w_live_vld && (!r_pend_vld || (w_live_idx <= r_pend_idx));

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_mis_nxt       = 1'b0;
    w_pend_vld_nxt  = r_pend_vld;
    w_pend_idx_nxt  = r_pend_idx;
    w_pend_addr_nxt = r_pend_addr;
    w_redirect      = 1'b0;
    w_tgt           = '0;
    case (r_state)
      IDLE: w_state_nxt = RUN;
      RUN: begin
        if (stall[0]) begin
          if (w_live_take) begin
            w_pend_vld_nxt  = 1'b1;
            w_pend_idx_nxt  = w_live_idx;
            w_pend_addr_nxt = w_live_addr;
          end
        end else begin
          if (w_live_take) begin
            w_redirect = 1'b1;
            w_tgt      = w_live_addr;
          end else if (r_pend_vld) begin
            w_redirect = 1'b1;
            w_tgt      = r_pend_addr;
          end
          if (w_redirect) begin
            w_pc_nxt       = w_tgt & ALIGN_MASK;
            w_mis_nxt      = |(w_tgt & ~ALIGN_MASK);
            w_pend_vld_nxt = 1'b0;
          end else begin
            w_pc_nxt = r_pc + STEP_V;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_pc        <= RESET_VEC;
      r_mis       <= 1'b0;
      r_pend_vld  <= 1'b0;
      r_pend_idx  <= '0;
      r_pend_addr <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_mis       <= w_mis_nxt;
      r_pend_vld  <= w_pend_vld_nxt;
      r_pend_idx  <= w_pend_idx_nxt;
      r_pend_addr <= w_pend_addr_nxt;
    end
  end

  assign pc         = r_pc;
  assign ce         = (r_state == RUN);
  assign redir_pend = r_pend_vld;
  assign misalign   = r_mis;

  generate
    if (STALL_W > 1) begin : g_stall_hi
      logic w_unused_stall;
      assign w_unused_stall = ^stall[STALL_W-1:1];
    end
  endgenerate

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - randomized and directed checking of pc_gen against a behavioural model.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  stall = '0;
  logic [2:0]  redir_vld = '0;
  logic [95:0] redir_addr = '0;
  logic [31:0] pc;
  logic        ce, redir_pend, misalign;

  int vec_cnt = 0;
  int err_cnt = 0;

  pc_gen dut (
    .clk(clk), .rst(rst), .stall(stall), .redir_vld(redir_vld),
    .redir_addr(redir_addr), .pc(pc), .ce(ce), .redir_pend(redir_pend),
    .misalign(misalign)
  );

  always #5 clk = ~clk;

  // Reference model: fetch state kept as plain values, updated from the rules each edge.
  bit          m_run;
  logic [31:0] m_pc;
  bit          m_mis;
  bit          m_pend;
  int          m_pidx;
  logic [31:0] m_paddr;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_run = 0; m_pc = 32'ha0000000; m_mis = 0; m_pend = 0; m_pidx = 0; m_paddr = '0;
    end else if (!m_run) begin
      m_run = 1; m_mis = 0;
    end else begin
      int live;
      bit take;
      logic [31:0] tgt;
      live = -1;
      for (int i = 0; i < 3; i++) if (redir_vld[i] && live < 0) live = i;
      take = (live >= 0) && (!m_pend || live <= m_pidx);
      m_mis = 0;
      if (stall[0]) begin
        if (take) begin
          m_pend = 1; m_pidx = live; m_paddr = redir_addr[live*32 +: 32];
        end
      end else if (take || m_pend) begin
        tgt = take ? redir_addr[live*32 +: 32] : m_paddr;
        m_pc = {tgt[31:2], 2'b00};
        m_mis = (tgt % 4) != 0;
        m_pend = 0;
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
  end

  always @(negedge clk) begin
    vec_cnt++;
    if (pc !== m_pc || ce !== m_run || redir_pend !== m_pend || misalign !== m_mis) begin
      err_cnt++;
      $display("FAIL model t=%0t pc=%h ce=%b pend=%b mis=%b expected pc=%h ce=%b pend=%b mis=%b",
               $time, pc, ce, redir_pend, misalign, m_pc, m_run, m_pend, m_mis);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [95:0] pk(input logic [31:0] a0, input logic [31:0] a1,
                                     input logic [31:0] a2);
    return {a2, a1, a0};
  endfunction

  // Called just after a negedge; returns at the next negedge with the edge's result visible.
  task automatic step(input bit s, input logic [2:0] v, input logic [95:0] a);
    stall = {5'b0, s};
    redir_vld = v;
    redir_addr = a;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk); @(negedge clk);
    chk("reset_pc", pc, 32'ha0000000);
    chk("reset_ce", 32'(ce), 0);
    chk("reset_pend", 32'(redir_pend), 0);

    // 1: reset release and sequential fetch
    rst = 1'b1;
    step(0, 3'b000, '0);
    chk("first_pc", pc, 32'ha0000000);
    chk("first_ce", 32'(ce), 1);
    step(0, 3'b000, '0); chk("seq1", pc, 32'ha0000004);
    step(0, 3'b000, '0); chk("seq2", pc, 32'ha0000008);

    // 2: priority
    step(0, 3'b110, pk(32'h0, 32'h1000, 32'h2000)); chk("prio_ch1", pc, 32'h1000);
    step(0, 3'b111, pk(32'h80000180, 32'h1000, 32'h2000)); chk("prio_ch0", pc, 32'h80000180);

    // 3: stall buffering
    step(1, 3'b010, pk(0, 32'h3000, 0));
    chk("buf_pend", 32'(redir_pend), 1);
    chk("buf_hold", pc, 32'h80000180);
    step(1, 3'b000, '0);
    step(1, 3'b000, '0); chk("buf_hold3", pc, 32'h80000180);
    step(0, 3'b000, '0);
    chk("buf_apply", pc, 32'h3000);
    chk("buf_clear", 32'(redir_pend), 0);

    // 4: merge while stalled, and live tie at release
    step(1, 3'b100, pk(0, 0, 32'h4000));
    step(1, 3'b001, pk(32'h5000, 0, 0));
    step(1, 3'b010, pk(0, 32'h6000, 0));
    step(0, 3'b000, '0); chk("merge", pc, 32'h5000);
    step(1, 3'b100, pk(0, 0, 32'h6ff0));
    step(0, 3'b100, pk(0, 0, 32'h7000)); chk("tie_live", pc, 32'h7000);

    // 5: misalign pulse and wrap
    step(0, 3'b010, pk(0, 32'h1002, 0));
    chk("mis_pc", pc, 32'h1000);
    chk("mis_hi", 32'(misalign), 1);
    step(0, 3'b000, '0); chk("mis_lo", 32'(misalign), 0);
    step(0, 3'b010, pk(0, 32'hfffffffc, 0)); chk("top", pc, 32'hfffffffc);
    step(0, 3'b000, '0); chk("wrap", pc, 32'h0);

    // 6: asynchronous reset while a redirect is pending
    step(1, 3'b010, pk(0, 32'h3000, 0));
    chk("ar_pend", 32'(redir_pend), 1);
    stall = 6'b1; redir_vld = '0;
    #2 rst = 1'b0;
    #1;
    chk("ar_pc", pc, 32'ha0000000);
    chk("ar_ce", 32'(ce), 0);
    chk("ar_pend0", 32'(redir_pend), 0);
    @(negedge clk);
    rst = 1'b1;
    step(0, 3'b000, '0); chk("ar_first", pc, 32'ha0000000);
    step(0, 3'b000, '0); chk("ar_seq", pc, 32'ha0000004);

    // random phase
    for (int n = 0; n < 600; n++) begin
      logic [95:0] a;
      logic [2:0] v;
      bit s;
      for (int c = 0; c < 3; c++) begin
        case ($urandom_range(0, 3))
          0: a[c*32 +: 32] = $urandom & 32'hfffffffc;
          1: a[c*32 +: 32] = $urandom;
          2: a[c*32 +: 32] = 32'hfffffffc;
          default: a[c*32 +: 32] = 32'hfffffff8 | 32'($urandom_range(0, 7));
        endcase
      end
      v = '0;
      for (int c = 0; c < 3; c++) v[c] = ($urandom_range(0, 5) == 0);
      s = ($urandom_range(0, 9) < 4);
      if ($urandom_range(0, 99) == 0) begin
        fork
          begin #2 rst = 1'b0; end
        join_none
        step(s, v, a);
        #2 rst = 1'b1;
        #1;
        @(negedge clk);
      end else begin
        step(s, v, a);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
